uart_rx_fifo: RTL

- Receive buffer and Wishbone register front-end that sits directly downstream of the UART receiver.
- Accepts one-byte push strobes from the receiver and stores bytes in a circular buffer of DEPTH entries.
- Exposes DATA, STATUS and CTRL registers to the CPU over a Wishbone classic slave port.
- A CPU read of DATA pops one byte.

---
 rtl/uart_rx_fifo_if.sv | 13 +
 rtl/uart_rx_fifo.sv | 105 ++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Wishbone classic register port of the UART receive buffer.
interface uart_rx_fifo_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [1:0]  adr;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack;

  modport master (output cyc, stb, we, adr, dat_i, input dat_o, ack);
  modport slave  (input cyc, stb, we, adr, dat_i, output dat_o, ack);
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive circular buffer with Wishbone DATA/STATUS/CTRL registers.
// Define UART_RX_IRQ_EN to add the registered irq output and STATUS[19].
module uart_rx_fifo #(
  parameter int DEPTH_LOG2    = 8,
  parameter int IRQ_THRESHOLD = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  uart_rx_fifo_if.slave wb
`ifdef UART_RX_IRQ_EN
  , output logic       irq
`endif
);
  localparam int            CW      = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(2**DEPTH_LOG2);
  localparam logic [0:0]    S_IDLE  = 1'b0;
  localparam logic [0:0]    S_ACK   = 1'b1;

  logic [7:0]            mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic [0:0]            state_q, state_d;
  logic [31:0]           dat_q, dat_d;
  logic                  irq_bit;
  logic                  req, empty, full, pop, flush, clr, space, push_ok, overflow;
  logic                  unused_dat;

  assign unused_dat = &{1'b0, wb.dat_i[31:2]};

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign req      = wb.cyc & wb.stb & (state_q == S_IDLE);
  assign pop      = req & ~wb.we & (wb.adr == 2'd0) & ~empty;
  assign flush    = req & wb.we & (wb.adr == 2'd2) & wb.dat_i[0];
  assign clr      = req & wb.we & (wb.adr == 2'd2) & wb.dat_i[1];
  // A pop in the same cycle frees a slot, so a full buffer still accepts the push.
  assign space    = ~full | pop;
  assign push_ok  = rx_valid & space & ~flush;
  assign overflow = rx_valid & ~space & ~flush;

  always_comb begin
    state_d   = (req) ? S_ACK : S_IDLE;
    dat_d     = dat_q;
    wr_ptr_d  = wr_ptr_q + DEPTH_LOG2'(push_ok);
    rd_ptr_d  = flush ? wr_ptr_q : rd_ptr_q + DEPTH_LOG2'(pop);
    count_d   = flush ? '0 : count_q + CW'(push_ok) - CW'(pop);
    overrun_d = (overrun_q & ~clr) | overflow;
    if (req) begin
      dat_d = '0;
      if (!wb.we) begin
        case (wb.adr)
          2'd0: if (pop) dat_d = {24'h0, mem_q[rd_ptr_q]};
          2'd1: begin
            dat_d[CW-1:0] = count_q;
            dat_d[16]     = empty;
            dat_d[17]     = full;
            dat_d[18]     = overrun_q;
            dat_d[19]     = irq_bit;
          end
          default: dat_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dat_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dat_q     <= dat_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_data;
  end

`ifdef UART_RX_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= (count_q >= CW'(IRQ_THRESHOLD)) | overrun_q;
  end
  assign irq     = irq_q;
  assign irq_bit = irq_q;
`else
  assign irq_bit = 1'b0;
`endif

  assign wb.ack   = (state_q == S_ACK);
  assign wb.dat_o = dat_q;
endmodule
